tm1638_key_reader: RTL and testbench



---
 rtl/tm1638_key_reader.sv | 134 +++++++++++++
 tb/tb_tm1638_key_reader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues the TM1638 key-scan command, clocks in four scan bytes
// LSB-first and publishes the 8-key vector plus newly-pressed pulses once per frame.
module tm1638_key_reader #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk_1,
    input  logic        RST,
    input  logic        start,
    input  logic        dio_in,
    output logic        stb,
    output logic        sclk,
    output logic        dio_out,
    output logic        dio_oe,
    output logic        busy,
    output logic        done,
    output logic [31:0] raw_data,
    output logic [7:0]  keys,
    output logic [7:0]  key_pressed
);
    typedef enum logic [2:0] {IDLE, CMD, WAIT, READ, STOP} state_t;
    localparam logic [7:0] CMD_BYTE = 8'h42;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stb_q, stb_d, sclk_q, sclk_d, dout_q, dout_d, oe_q, oe_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] sr_q, sr_d, raw_q, raw_d;
    logic [7:0]  keys_q, keys_d, kp_q, kp_d, map;
    // Keys live in bits 0 and 4 of each scan byte
    assign map = {sr_q[28], sr_q[20], sr_q[12], sr_q[4], sr_q[24], sr_q[16], sr_q[8], sr_q[0]};
    always_ff @(posedge Clk_1 or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stb_q   <= 1'b1;
            sclk_q  <= 1'b1;
            dout_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sr_q    <= '0;
            raw_q   <= '0;
            keys_q  <= '0;
            kp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            sclk_q  <= sclk_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sr_q    <= sr_d;
            raw_q   <= raw_d;
            keys_q  <= keys_d;
            kp_q    <= kp_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        sclk_d  = sclk_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sr_d    = sr_q;
        raw_d   = raw_q;
        keys_d  = keys_q;
        kp_d    = '0;
        case (state_q)
            IDLE: begin
                stb_d  = 1'b1;
                sclk_d = 1'b1;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                // the cycle after done still belongs to the finished frame
                if (start && !done_q) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                sclk_d = cnt_q[0];
                if (!cnt_q[0]) begin
                    oe_d   = 1'b1;
                    dout_d = CMD_BYTE[cnt_q[3:1]];
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd15) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                oe_d   = 1'b0;
                dout_d = 1'b0;
                sclk_d = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                sclk_d = cnt_q[0];
                if (cnt_q[0]) sr_d[cnt_q[5:1]] = dio_in;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd63) state_d = STOP;
            end
            default: begin
                stb_d   = 1'b1;
                sclk_d  = 1'b1;
                raw_d   = sr_q;
                keys_d  = map;
                kp_d    = map & ~keys_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    assign stb         = stb_q;
    assign sclk        = sclk_q;
    assign dio_out     = dout_q;
    assign dio_oe      = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign raw_data    = raw_q;
    assign keys        = keys_q;
    assign key_pressed = kp_q;
endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader: two readers (WAIT_CYCLES 2 and 5) against a behavioural
// TM1638 key-scan device; frames checked from tables and random data.
module tb_tm1638_key_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [1:0]  dio_in = 2'b00;
    logic [1:0]  stb, sclk, dio_out, dio_oe, busy, done;
    logic [1:0]  prev_sclk = 2'b11;
    logic [31:0] raw[2];
    logic [7:0]  keys[2], kp[2];
    logic [31:0] dev_data[2];
    logic [7:0]  cmd_cap[2];
    int          viol[2], rises[2], nf[2];
    bit          seen8[2];
    int          checks = 0, failures = 0;
    logic [7:0]  prev_keys = 8'h00;
    typedef struct {
        logic [31:0] d;
        logic [7:0]  k;
        logic [7:0]  p;
    } vec_t;
    vec_t tab[6];

    always #5 clk = ~clk;

    tm1638_key_reader #(.WAIT_CYCLES(2)) dut (
        .Clk_1(clk), .RST(rst), .start(start[0]), .dio_in(dio_in[0]),
        .stb(stb[0]), .sclk(sclk[0]), .dio_out(dio_out[0]), .dio_oe(dio_oe[0]),
        .busy(busy[0]), .done(done[0]), .raw_data(raw[0]), .keys(keys[0]), .key_pressed(kp[0]));
    tm1638_key_reader #(.WAIT_CYCLES(5)) dut5 (
        .Clk_1(clk), .RST(rst), .start(start[1]), .dio_in(dio_in[1]),
        .stb(stb[1]), .sclk(sclk[1]), .dio_out(dio_out[1]), .dio_oe(dio_oe[1]),
        .busy(busy[1]), .done(done[1]), .raw_data(raw[1]), .keys(keys[1]), .key_pressed(kp[1]));

    // Device model: latches command bits on CLK rises, shifts out scan data after
    // the eighth CLK fall; also flags any DIO drive after the command byte.
    initial begin
        viol[0] = 0; viol[1] = 0; rises[0] = 0; rises[1] = 0; nf[0] = 0; nf[1] = 0;
        cmd_cap[0] = 8'h00; cmd_cap[1] = 8'h00;
    end
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (stb[g]) begin
                rises[g] = 0;
                nf[g] = 0;
                seen8[g] = 0;
                if (dio_oe[g]) viol[g]++;
            end else begin
                if (!prev_sclk[g] && sclk[g]) begin
                    if (rises[g] < 8) cmd_cap[g][rises[g]] = dio_out[g];
                    rises[g]++;
                end
                if (prev_sclk[g] && !sclk[g]) begin
                    nf[g]++;
                    if (nf[g] > 8 && nf[g] <= 40) dio_in[g] = dev_data[g][nf[g] - 9];
                end
                if (seen8[g] && dio_oe[g]) viol[g]++;
                if (rises[g] >= 8) seen8[g] = 1;
            end
            prev_sclk[g] = sclk[g];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] keys_of(input logic [31:0] d);
        logic [7:0] k;
        for (int i = 0; i < 4; i++) begin
            k[i] = d[8 * i];
            k[i + 4] = d[8 * i + 4];
        end
        return k;
    endfunction

    task automatic run(input string tag, input int g, input logic [31:0] d, input int pulse_at,
                       input int exp_done, input int exp_wait, input logic [7:0] ek, input logic [7:0] ekp);
        int done_at, ndone, oe_drop, wait_n, v0;
        bit oe_seen, fell, busy_ok, kp_ok, stb_ok;
        logic [31:0] r;
        logic [7:0] k, p;
        oe_seen = 0; fell = 0; busy_ok = 1; kp_ok = 1;
        done_at = -1; ndone = 0; oe_drop = -1; wait_n = 0;
        r = '0; k = '0; p = '0;
        dev_data[g] = d;
        v0 = viol[g];
        @(negedge clk); start[g] = 1'b1;
        @(negedge clk); start[g] = 1'b0;
        stb_ok = !stb[g] && busy[g];
        for (int e = 1; e <= 110; e++) begin
            start[g] = (e == pulse_at);
            @(negedge clk);
            if (dio_oe[g]) oe_seen = 1;
            else if (oe_seen && oe_drop < 0) oe_drop = e;
            if (oe_drop >= 0 && !fell) begin
                if (sclk[g]) wait_n++;
                else fell = 1;
            end
            if (done_at < 0 && !busy[g]) busy_ok = 0;
            if (done_at >= 0 && busy[g]) busy_ok = 0;
            if (!done[g] && kp[g] != 8'h00) kp_ok = 0;
            if (done[g]) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = e; r = raw[g]; k = keys[g]; p = kp[g];
                end
            end
        end
        start[g] = 1'b0;
        chk({tag, " done_edge"}, done_at, exp_done);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " raw_data"}, r, d);
        chk({tag, " keys"}, {24'h0, k}, {24'h0, ek});
        chk({tag, " key_pressed"}, {24'h0, p}, {24'h0, ekp});
        chk({tag, " busy_window"}, 32'(busy_ok), 1);
        chk({tag, " kp_outside_done"}, 32'(kp_ok), 1);
        chk({tag, " stb_fall_E0"}, 32'(stb_ok), 1);
        chk({tag, " command"}, {24'h0, cmd_cap[g]}, 32'h42);
        chk({tag, " dio_contention"}, viol[g] - v0, 0);
        chk({tag, " oe_drop_edge"}, oe_drop, 17);
        chk({tag, " wait_cycles"}, wait_n, exp_wait);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0] k;
        int nd;
        tab[0] = '{32'h00000000, 8'h00, 8'h00};
        tab[1] = '{32'h11001001, 8'hA9, 8'hA9};
        tab[2] = '{32'h10000001, 8'h81, 8'h00};
        tab[3] = '{32'hEEEEEEEE, 8'h00, 8'h00};
        tab[4] = '{32'h11111111, 8'hFF, 8'hFF};
        tab[5] = '{32'h00100000, 8'h40, 8'h00};
        dev_data[0] = '0; dev_data[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset stb", 32'(stb), 32'h3);
        chk("reset sclk", 32'(sclk), 32'h3);
        chk("reset dio_oe/out", {30'h0, dio_oe | dio_out}, 0);
        chk("reset busy/done", {30'h0, busy | done}, 0);
        chk("reset raw_data", raw[0], 0);
        chk("reset keys", {24'h0, keys[0] | kp[0]}, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run($sformatf("table%0d", i), 0, tab[i].d, 0, 83, 2, tab[i].k, tab[i].p);
        prev_keys = tab[5].k;
        // start pulsed again mid-frame must be dropped, not queued
        d = $urandom | 32'h1;
        k = keys_of(d);
        run("restart_ignored", 0, d, 30, 83, 2, k, k & ~prev_keys);
        prev_keys = k;
        // reset in the middle of READ
        dev_data[0] = $urandom;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (39) @(negedge clk);
        chk("midframe stb low", 32'(stb[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("abort stb", 32'(stb[0]), 1);
        chk("abort dio_oe", 32'(dio_oe[0]), 0);
        chk("abort sclk", 32'(sclk[0]), 1);
        chk("abort busy", 32'(busy[0]), 0);
        chk("abort keys", {24'h0, keys[0]}, 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        rst = 1'b0;
        chk("abort no done", nd, 0);
        prev_keys = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = (i % 3 == 0) ? ($urandom & $urandom) : $urandom;
            k = keys_of(d);
            run($sformatf("random%0d", i), 0, d, 0, 83, 2, k, k & ~prev_keys);
            prev_keys = k;
        end
        run("wait5", 1, 32'hFFFFFFFF, 0, 86, 5, 8'hFF, 8'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
